// File: rtl/serial_borrow_subtractor.sv
// serial_borrow_subtractor
//   Computes d = a - b - bin (modulo 2^WIDTH) two bits per cycle, LSB slice
//   first, using a 2-bit borrow-lookahead slice. A run takes WIDTH/2 RUN
//   cycles followed by one DONE cycle, which carries the done strobe.
//
// Ports
//   clk    rising-edge clock
//   rst_n  synchronous active-low reset
//   start  begin a subtraction; accepted only while busy=0 (IDLE or DONE)
//   a, b   minuend / subtrahend (WIDTH bits), bin borrow-in
//   busy   high while slices are being processed
//   done   one-cycle strobe; d/bout/ovf/zero are valid from this cycle and
//          hold until the next accepted start
//   d      difference, bout borrow out of bit WIDTH-1
//   ovf    signed two's-complement overflow, zero  d == 0
//
// WIDTH must be even and at least 4.
module serial_borrow_subtractor #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] d,
    output logic             bout,
    output logic             ovf,
    output logic             zero
);

    localparam int SLICES = WIDTH / 2;
    localparam int CW     = (SLICES > 1) ? $clog2(SLICES) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    // Operands shift right two bits per slice, so bits [1:0] are always the
    // current slice; the sign bits are kept aside for the overflow flag.
    logic [WIDTH-1:0] opa_q, opa_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    logic             a_msb_q, a_msb_d;
    logic             b_msb_q, b_msb_d;
    logic             br_q, br_d;
    // Difference bits enter at the top and shift down; after SLICES shifts
    // slice 0 lands at bits [1:0].
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic             bout_q, bout_d;
    logic             ovf_q, ovf_d;
    logic             zero_q, zero_d;

    // 2-bit borrow-lookahead slice
    logic g0, g1, p0, p1, s0, s1, br1, brout, last;
    logic [WIDTH-1:0] acc_next;

    always_comb begin
        g0       = ~opa_q[0] & opb_q[0];
        g1       = ~opa_q[1] & opb_q[1];
        p0       = ~(opa_q[0] ^ opb_q[0]);
        p1       = ~(opa_q[1] ^ opb_q[1]);
        br1      = g0 | (p0 & br_q);
        brout    = g1 | (p1 & g0) | (p1 & p0 & br_q);
        s0       = opa_q[0] ^ opb_q[0] ^ br_q;
        s1       = opa_q[1] ^ opb_q[1] ^ br1;
        acc_next = {s1, s0, acc_q[WIDTH-1:2]};
        last     = (cnt_q == CW'(SLICES - 1));
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        a_msb_d = a_msb_q;
        b_msb_d = b_msb_q;
        br_d    = br_q;
        acc_d   = acc_q;
        d_d     = d_q;
        bout_d  = bout_q;
        ovf_d   = ovf_q;
        zero_d  = zero_q;

        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (start) begin
                    state_d = RUN;
                    cnt_d   = '0;
                    opa_d   = a;
                    opb_d   = b;
                    a_msb_d = a[WIDTH-1];
                    b_msb_d = b[WIDTH-1];
                    br_d    = bin;
                    acc_d   = '0;
                end
            end
            RUN: begin
                opa_d = opa_q >> 2;
                opb_d = opb_q >> 2;
                br_d  = brout;
                acc_d = acc_next;
                cnt_d = cnt_q + CW'(1);
                if (last) begin
                    // Visible results change only on entry to DONE.
                    state_d = DONE;
                    d_d     = acc_next;
                    bout_d  = brout;
                    ovf_d   = (a_msb_q != b_msb_q) & (acc_next[WIDTH-1] != a_msb_q);
                    zero_d  = (acc_next == '0);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            opa_q   <= '0;
            opb_q   <= '0;
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
            br_q    <= 1'b0;
            acc_q   <= '0;
            d_q     <= '0;
            bout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            a_msb_q <= a_msb_d;
            b_msb_q <= b_msb_d;
            br_q    <= br_d;
            acc_q   <= acc_d;
            d_q     <= d_d;
            bout_q  <= bout_d;
            ovf_q   <= ovf_d;
            zero_q  <= zero_d;
        end
    end

    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);
    assign d    = d_q;
    assign bout = bout_q;
    assign ovf  = ovf_q;
    assign zero = zero_q;

endmodule

// File: tb/tb_serial_borrow_subtractor.sv
module tb_serial_borrow_subtractor;

    localparam int W      = 64;
    localparam int LAT    = W / 2 + 1;
    localparam int N_RAND = 2000;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a, b;
    logic         bin;
    logic         busy, done;
    logic [W-1:0] d;
    logic         bout, ovf, zero;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    serial_borrow_subtractor #(.WIDTH(W)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .start(start),
        .a    (a),
        .b    (b),
        .bin  (bin),
        .busy (busy),
        .done (done),
        .d    (d),
        .bout (bout),
        .ovf  (ovf),
        .zero (zero)
    );

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] want);
        checks++;
        assert (obs === want) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, want);
        end
    endtask

    // Reference: wide unsigned and signed arithmetic on the operands.
    task automatic model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic mbin,
                         output logic [W-1:0] md, output logic mbout,
                         output logic movf, output logic mzero);
        logic [W:0]          full;
        logic signed [W+1:0] s;
        full  = {1'b0, ma} - {1'b0, mb} - (W+1)'(mbin);
        md    = full[W-1:0];
        mbout = full[W];
        s     = $signed({ma[W-1], ma[W-1], ma}) - $signed({mb[W-1], mb[W-1], mb})
              - $signed({{(W+1){1'b0}}, mbin});
        movf  = (s > $signed({2'b00, 1'b0, {(W-1){1'b1}}})) ||
                (s < $signed({2'b11, 1'b1, {(W-1){1'b0}}}));
        mzero = (md == '0);
    endtask

    task automatic check_result(input string tag, input logic [W-1:0] ma,
                                input logic [W-1:0] mb, input logic mbin);
        logic [W-1:0] ed;
        logic eb, eo, ez;
        model(ma, mb, mbin, ed, eb, eo, ez);
        check({tag, "_d"},    d,    ed);
        check({tag, "_bout"}, W'(bout), W'(eb));
        check({tag, "_ovf"},  W'(ovf),  W'(eo));
        check({tag, "_zero"}, W'(zero), W'(ez));
    endtask

    function automatic logic [W-1:0] rnd64();
        return {$urandom(), $urandom()};
    endfunction

    // One operation from IDLE; optionally re-pulse start mid-run with junk.
    task automatic run_op(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb,
                          input logic tbin, input bit repulse);
        int n;
        logic [W-1:0] held;
        @(negedge clk);
        a = ta; b = tb; bin = tbin; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 1;
        check({tag, "_busy_run"}, W'(busy), W'(1));
        while (!done && n < 100) begin
            if (repulse && (n == 5 || n == 20)) begin
                start = 1'b1; a = rnd64(); b = rnd64(); bin = ~tbin;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            n++;
        end
        start = 1'b0;
        check({tag, "_latency"}, W'(n), W'(LAT));
        check({tag, "_done_busy"}, {62'd0, done, busy}, {62'd0, 2'b10});
        check_result(tag, ta, tb, tbin);
        held = d;
        @(negedge clk);
        check({tag, "_done_drop"}, {62'd0, done, busy}, 64'd0);
        check({tag, "_hold"}, d, held);
    endtask

    initial begin
        int n;
        bit saw_done;
        logic [W-1:0] ca, cb;
        logic cbin;

        rst_n = 1'b0; start = 1'b1; a = '1; b = '0; bin = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ctrl", {62'd0, busy, done}, 64'd0);
        check("rst_d", d, '0);
        check("rst_flags", {61'd0, bout, ovf, zero}, 64'd0);
        start = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_after_rst", {62'd0, busy, done}, 64'd0);

        run_op("small",  64'd5, 64'd3, 1'b0, 1'b0);
        run_op("under",  64'd0, 64'd1, 1'b0, 1'b0);
        run_op("ovf",    64'h8000_0000_0000_0000, 64'd1, 1'b0, 1'b0);
        run_op("zero",   64'h1234, 64'h1234, 1'b0, 1'b0);
        run_op("binrep", 64'd7, 64'd7, 1'b1, 1'b1);
        run_op("povf",   64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0);

        // Abort at cycle 10 of a run; reset wins over a simultaneous start.
        @(negedge clk);
        a = 64'hDEAD_BEEF; b = 64'h1; bin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 1;
        while (n < 10) begin @(negedge clk); n++; end
        rst_n = 1'b0; start = 1'b1; a = 64'd9;
        @(negedge clk);
        check("abort_ctrl", {62'd0, busy, done}, 64'd0);
        check("abort_d", d, '0);
        check("abort_flags", {61'd0, bout, ovf, zero}, 64'd0);
        rst_n = 1'b1; start = 1'b0;
        saw_done = 1'b0;
        repeat (40) begin @(negedge clk); saw_done |= done; end
        check("abort_no_done", W'(saw_done), W'(0));
        run_op("after_abort", 64'h1_0000_0000, 64'h2, 1'b1, 1'b0);

        // Back-to-back with start held high.
        @(negedge clk);
        ca = rnd64(); cb = rnd64(); cbin = 1'(($urandom() & 1));
        a = ca; b = cb; bin = cbin; start = 1'b1;
        for (int k = 0; k < N_RAND; k++) begin
            n = 0;
            do begin @(negedge clk); n++; end while (!done && n < 100);
            check("b2b_gap", W'(n), W'(LAT));
            check_result("b2b", ca, cb, cbin);
            case ($urandom_range(0, 4))
                0:       begin ca = rnd64(); cb = ca; end
                1:       begin ca = '0; cb = rnd64(); end
                2:       begin ca = rnd64(); cb = ca ^ 64'h8000_0000_0000_0000; end
                default: begin ca = rnd64(); cb = rnd64(); end
            endcase
            cbin = 1'(($urandom() & 1));
            a = ca; b = cb; bin = cbin;
        end
        start = 1'b0;
        repeat (2) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
